pipe_hazard_ctrl: RTL

//  Central control unit for the 5-stage Y86-64 pipeline (F/D/E/M/W).

---
 rtl/y86_pkg.sv | 37 +++
 rtl/hazard_detect.sv | 57 +++++
 rtl/pipe_hazard_ctrl.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 pipeline definitions: icodes, one-hot status codes, register ids and
// the pipeline control FSM encoding.
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [2:0] STAT_AOK = 3'b001;
  localparam logic [2:0] STAT_ERR = 3'b010;
  localparam logic [2:0] STAT_HLT = 3'b100;

  localparam logic [3:0] RSP_ID = 4'h4;
  localparam logic [3:0] RNONE  = 4'hF;

  typedef enum logic [1:0] {
    StRun   = 2'd0,
    StDrain = 2'd1,
    StStop  = 2'd2
  } state_e;

  // True when a real destination register matches either source operand.
  function automatic logic reg_hit(input logic [3:0] dst, input logic [3:0] src_a,
                                   input logic [3:0] src_b, input logic [3:0] none_id);
    return (dst != none_id) && ((dst == src_a) || (dst == src_b));
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational source/destination decode for the decode and execute stages, producing
// the load-use, return and mispredict hazard terms.
module hazard_detect
  import y86_pkg::*;
#(
  parameter logic [3:0] RspId   = 4'h4,
  parameter logic [3:0] RegNone = 4'hF
) (
  input  logic [3:0] d_icode_i,
  input  logic [3:0] d_reg_a_i,
  input  logic [3:0] d_reg_b_i,
  input  logic [3:0] e_icode_i,
  input  logic [3:0] e_reg_a_i,
  input  logic       e_cond_i,
  input  logic [3:0] m_icode_i,
  output logic       lu_o,
  output logic       ret_o,
  output logic       mp_o
);

  logic [3:0] d_src_a;
  logic [3:0] d_src_b;
  logic [3:0] e_dst_m;

  always_comb begin
    d_src_a = RegNone;
    case (d_icode_i)
      IRRMOVQ, IRMMOVQ, IOPQ, IPUSHQ: d_src_a = d_reg_a_i;
      IRET, IPOPQ:                    d_src_a = RspId;
      default:                        d_src_a = RegNone;
    endcase
  end

  always_comb begin
    d_src_b = RegNone;
    case (d_icode_i)
      IRMMOVQ, IMRMOVQ, IOPQ:     d_src_b = d_reg_b_i;
      ICALL, IRET, IPUSHQ, IPOPQ: d_src_b = RspId;
      default:                    d_src_b = RegNone;
    endcase
  end

  // Only loads (mrmovq/popq) produce a value late enough to need a stall.
  always_comb begin
    e_dst_m = RegNone;
    if ((e_icode_i == IMRMOVQ) || (e_icode_i == IPOPQ)) begin
      e_dst_m = e_reg_a_i;
    end
  end

  always_comb begin
    lu_o  = reg_hit(e_dst_m, d_src_a, d_src_b, RegNone);
    ret_o = (d_icode_i == IRET) || (e_icode_i == IRET) || (m_icode_i == IRET);
    mp_o  = (e_icode_i == IJXX) && !e_cond_i;
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central Y86-64 pipeline control: stall/bubble generation, CC gating and the run/drain/stop
// retirement FSM. Performance counters are built only when PIPE_PERF_CNT_EN is defined.
module pipe_hazard_ctrl
  import y86_pkg::*;
#(
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned DRAIN_MAX = 8,
  parameter logic [3:0]  RSP_ID    = y86_pkg::RSP_ID,
  parameter logic [3:0]  RNONE     = y86_pkg::RNONE
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [2:0]       f_stat,
  input  logic [3:0]       d_icode,
  input  logic [3:0]       d_regA,
  input  logic [3:0]       d_regB,
  input  logic [3:0]       e_icode,
  input  logic [3:0]       e_regA,
  input  logic             e_cond,
  input  logic [3:0]       m_icode,
  input  logic [2:0]       m_stat,
  input  logic [2:0]       w_stat,
  output logic             f_stall,
  output logic             d_stall,
  output logic             d_bubble,
  output logic             e_bubble,
  output logic             m_bubble,
  output logic             w_stall,
  output logic             set_cc_en,
  output logic [2:0]       cpu_stat,
  output logic             done
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] lu_cnt,
  output logic [CNT_W-1:0] mp_cnt,
  output logic [CNT_W-1:0] ret_cnt
`endif
);

  localparam int unsigned WdW = (DRAIN_MAX > 1) ? $clog2(DRAIN_MAX) : 1;
  localparam logic [WdW-1:0] WdLast = WdW'(DRAIN_MAX - 1);

  logic lu, ret, mp, exc;
  logic w_bad, f_bad;

  state_e         state_q, state_d;
  logic [WdW-1:0] wd_q, wd_d;
  logic [2:0]     cpu_stat_q, cpu_stat_d;
  logic           done_q, done_d;

  hazard_detect #(
    .RspId   (RSP_ID),
    .RegNone (RNONE)
  ) u_hazard_detect (
    .d_icode_i (d_icode),
    .d_reg_a_i (d_regA),
    .d_reg_b_i (d_regB),
    .e_icode_i (e_icode),
    .e_reg_a_i (e_regA),
    .e_cond_i  (e_cond),
    .m_icode_i (m_icode),
    .lu_o      (lu),
    .ret_o     (ret),
    .mp_o      (mp)
  );

  assign w_bad = (w_stat != STAT_AOK);
  assign f_bad = (f_stat != STAT_AOK);
  assign exc   = (m_stat != STAT_AOK) || w_bad;

  always_comb begin
    state_d    = state_q;
    wd_d       = wd_q;
    cpu_stat_d = cpu_stat_q;
    unique case (state_q)
      StRun: begin
        wd_d = '0;
        if (w_bad) begin
          state_d    = StStop;
          cpu_stat_d = w_stat;
        end else if (f_bad) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (w_bad) begin
          state_d    = StStop;
          cpu_stat_d = w_stat;
        end else if (wd_q == WdLast) begin
          // Nothing retired a bad status in time: force an error stop.
          state_d    = StStop;
          cpu_stat_d = STAT_ERR;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      StStop: begin
        state_d = StStop;
      end
      default: begin
        state_d = StStop;
      end
    endcase
    done_d = (state_d == StStop);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StRun;
      wd_q       <= '0;
      cpu_stat_q <= STAT_AOK;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wd_q       <= wd_d;
      cpu_stat_q <= cpu_stat_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    f_stall   = 1'b0;
    d_stall   = 1'b0;
    d_bubble  = 1'b1;
    e_bubble  = 1'b1;
    m_bubble  = 1'b1;
    w_stall   = 1'b0;
    set_cc_en = 1'b0;
    if (reset_n) begin
      f_stall   = lu | ret | (state_q != StRun);
      d_stall   = lu | (state_q == StStop);
      d_bubble  = (mp | ret) & ~lu & (state_q != StStop);
      e_bubble  = (mp | lu) & (state_q != StStop);
      m_bubble  = exc & (state_q != StStop);
      w_stall   = w_bad | (state_q == StStop);
      set_cc_en = (e_icode == IOPQ) & ~exc & (state_q == StRun);
    end
  end

  assign cpu_stat = cpu_stat_q;
  assign done     = done_q;

`ifdef PIPE_PERF_CNT_EN
  logic             counting;
  logic [CNT_W-1:0] cyc_cnt_q, cyc_cnt_d;
  logic [CNT_W-1:0] lu_cnt_q, lu_cnt_d;
  logic [CNT_W-1:0] mp_cnt_q, mp_cnt_d;
  logic [CNT_W-1:0] ret_cnt_q, ret_cnt_d;

  assign counting = (state_q != StStop);

  always_comb begin
    cyc_cnt_d = cyc_cnt_q + CNT_W'(counting);
    lu_cnt_d  = lu_cnt_q + CNT_W'(counting & lu);
    mp_cnt_d  = mp_cnt_q + CNT_W'(counting & mp);
    ret_cnt_d = ret_cnt_q + CNT_W'(counting & ret & ~lu);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cyc_cnt_q <= '0;
      lu_cnt_q  <= '0;
      mp_cnt_q  <= '0;
      ret_cnt_q <= '0;
    end else begin
      cyc_cnt_q <= cyc_cnt_d;
      lu_cnt_q  <= lu_cnt_d;
      mp_cnt_q  <= mp_cnt_d;
      ret_cnt_q <= ret_cnt_d;
    end
  end

  assign cyc_cnt = cyc_cnt_q;
  assign lu_cnt  = lu_cnt_q;
  assign mp_cnt  = mp_cnt_q;
  assign ret_cnt = ret_cnt_q;
`else
  logic [CNT_W-1:0] unused_cnt_w;
  assign unused_cnt_w = '0;
`endif

endmodule
